// File: rtl/quantum_pkg.sv
// Shared quantum-controller types: issue-stage FUNCT3 encodings and the pulse descriptor
// handed from the issue stage to the pulse scheduler.
package quantum_pkg;

  localparam logic [2:0] FUNCT3_PULSE = 3'b000;
  localparam logic [2:0] FUNCT3_WAIT  = 3'b001;
  localparam logic [2:0] FUNCT3_SYNC  = 3'b010;
  localparam logic [2:0] FUNCT3_MEAS  = 3'b011;

  localparam int PULSE_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pulse_mem_addr;
    logic [11:0] delay;
  } pulse_descriptor_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_ISSUE = 2'd2
  } disp_state_t;

endpackage

// File: rtl/pulse_fifo.sv
// Pulse-descriptor FIFO: registered storage, head readable one cycle after push.
// Pushes while full are ignored; full/empty are decodes of the registered count.
module pulse_fifo
  import quantum_pkg::*;
#(
  parameter int DEPTH = PULSE_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_vld,
  input  pulse_descriptor_t       push_dat,
  input  logic                    pop_vld,
  output pulse_descriptor_t       pop_dat,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  pulse_descriptor_t mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push_vld && !full;
  assign pop_ok  = pop_vld && !empty;
  assign pop_dat = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pulse_scheduler.sv
// Pulse scheduler: queues descriptors, waits delay D, then holds pulse_start until pulse_ack.
// pulse_start rises D+1 cycles after the pop; pushes into a full queue are dropped and flag overflow.
module pulse_scheduler
  import quantum_pkg::*;
#(
  parameter int DEPTH = PULSE_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  pulse_descriptor_t       pulse_descriptor,
  input  logic                    pulse_descriptor_valid,
  output logic                    pulse_register_full,
  output logic                    pulse_register_empty,
  output logic                    pulse_start,
  output logic [31:0]             pulse_addr,
  input  logic                    pulse_ack,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    overflow
);

  disp_state_t       state_q;
  disp_state_t       state_d;
  logic [11:0]       counter_q;
  logic [11:0]       counter_d;
  logic [31:0]       addr_q;
  logic [31:0]       addr_d;
  logic              fifo_pop_vld;
  pulse_descriptor_t fifo_head_dat;
  logic              fifo_full;
  logic              fifo_empty;

  pulse_fifo #(
    .DEPTH (DEPTH)
  ) u_pulse_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (pulse_descriptor_valid),
    .push_dat (pulse_descriptor),
    .pop_vld  (fifo_pop_vld),
    .pop_dat  (fifo_head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (occupancy)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      counter_q <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      addr_q    <= addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    addr_d       = addr_q;
    fifo_pop_vld = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop_vld = 1'b1;
          addr_d       = fifo_head_dat.pulse_mem_addr;
          if (fifo_head_dat.delay == 12'd0) begin
            state_d = ST_ISSUE;
          end else begin
            state_d   = ST_COUNT;
            counter_d = fifo_head_dat.delay;
          end
        end
      end
      ST_COUNT: begin
        counter_d = counter_q - 12'd1;
        // Leaving at 1 (not 0) gives exactly D cycles in COUNT.
        if (counter_q <= 12'd1) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (pulse_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky; the registered full flag is the pre-pop occupancy, so a same-cycle pop cannot save the push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (pulse_descriptor_valid && fifo_full) begin
      overflow <= 1'b1;
    end
  end

  assign pulse_start          = (state_q == ST_ISSUE);
  assign pulse_addr           = addr_q;
  assign pulse_register_full  = fifo_full;
  assign pulse_register_empty = fifo_empty && (state_q == ST_IDLE);

endmodule

// File: doc/pulse_scheduler.md
PULSE_SCHEDULER -- requirements
Module: pulse_scheduler

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the pulse-descriptor FIFO depth (power of two, >=2).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pulse_descriptor  input  pulse_descriptor_t  {pulse_mem_addr[31:0], delay[11:0]} from the quantum issue stage.
REQ-005 pulse_descriptor_valid  input  1  push strobe; each high cycle is one push request.
REQ-006 pulse_register_full  output  1  FIFO holds DEPTH entries.
REQ-007 pulse_register_empty  output  1  FIFO empty AND dispatcher idle (no pulse pending or in flight).
REQ-008 pulse_start  output  1  request to pulse playback; held until acknowledged.
REQ-009 pulse_addr  output  32  pulse memory address; valid while pulse_start=1.
REQ-010 pulse_ack  input  1  playback accepts the current pulse.
REQ-011 occupancy  output  $clog2(DEPTH)+1  FIFO entry count.
REQ-012 overflow  output  1  sticky: a push was dropped because the FIFO was full.

Function
REQ-013 A push SHALL be accepted iff pulse_descriptor_valid=1 and occupancy<DEPTH at that edge; the full check SHALL NOT consider a same-cycle pop.
REQ-014 A push with occupancy=DEPTH SHALL be dropped, FIFO unchanged, overflow set to 1 from the next cycle.
REQ-015 FIFO SHALL be strict FIFO order; read/write pointers SHALL wrap modulo DEPTH.
REQ-016 Simultaneous accepted push and pop SHALL leave occupancy unchanged.
REQ-017 Dispatcher states: IDLE, COUNT, ISSUE.
REQ-018 IDLE: if occupancy>0, pop head, latch addr and delay D; next state ISSUE if D=0, else COUNT with counter=D.
REQ-019 COUNT: counter SHALL decrement by 1 per cycle; when counter=1, next state ISSUE.
REQ-020 Net latency: pulse_start SHALL first assert exactly D+1 cycles after the pop cycle (D=0..4095, 12-bit unsigned, no wrap).
REQ-021 ISSUE: pulse_start=1 and pulse_addr=latched addr; on a cycle with pulse_ack=1, next state IDLE, pulse_start=0 next cycle.
REQ-022 pulse_ack outside ISSUE SHALL be ignored.
REQ-023 A push into an empty FIFO SHALL be poppable no earlier than the next cycle (registered storage).
REQ-024 pulse_register_full and pulse_register_empty SHALL be registered-state decodes, no combinational path from inputs.
REQ-025 pulse_addr SHALL hold its last value outside ISSUE.

Reset
REQ-026 Reset SHALL, asynchronously and in any state: state=IDLE, pointers/occupancy=0, counter=0, pulse_start=0, pulse_addr=0, overflow=0, pulse_register_full=0, pulse_register_empty=1.
REQ-027 A pulse in COUNT or ISSUE at reset SHALL be discarded; no pulse_start after reset release without a new push.
REQ-028 FIFO storage contents SHALL need no reset.

Structure
REQ-029 pulse_descriptor_t and the default depth constant PULSE_FIFO_DEPTH SHALL live in the shared quantum package with the FUNCT3 constants.
REQ-030 Storage SHALL be one sub-module, pulse_fifo (push/pop/full/empty/count); FSM and counter SHALL be in pulse_scheduler.

Verification
REQ-031 Reset, push {addr=0x100, D=0} at cycle 0, ack tied 1 -> pulse_start=1 with addr 0x100 at cycle 2 only; empty=1 at cycle 4.
REQ-032 Push {0x200, D=5} at cycle 0, ack tied 1 -> pulse_start first high cycle 7; no earlier assertion.
REQ-033 Ack held 0 for 10 cycles in ISSUE -> pulse_start and pulse_addr stable all 10 cycles; drops one cycle after ack=1.
REQ-034 DEPTH=4, ack=0, 6 consecutive pushes addr 1..6 D=0 -> first pops, full=1 after 5 accepted, push 6 dropped, overflow=1; release ack -> pulses issue in order 1..5.
REQ-035 Push {0x300, D=4095}, assert reset at COUNT cycle 2000 -> all outputs at reset values immediately; no pulse_start for 5000 cycles after release.
REQ-036 Back-to-back pushes D=3 each with ack tied 1 -> each start spaced by 1(IDLE)+1(ack cycle)+3 cycles; occupancy never exceeds 2.
